btb_update_unit: RTL

// Producer side of the branch target buffer write port. Takes resolved branches from execute,

---
 rtl/btb_update_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/btb_update_unit.sv
// BTB update producer: classifies resolved branches, pulses fetch redirects on mispredict,
// queues target writes toward the BTB write port and keeps saturating statistics.
module btb_update_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ex_valid,
  input  logic [ADDR_WIDTH-1:0] i_ex_pc,
  input  logic                  i_ex_taken,
  input  logic [ADDR_WIDTH-1:0] i_ex_target,
  input  logic                  i_ex_pred_hit,
  input  logic [ADDR_WIDTH-1:0] i_ex_pred_target,
  output logic                  o_redirect_valid,
  output logic [ADDR_WIDTH-1:0] o_redirect_pc,
  output logic                  o_wr_valid,
  output logic [ADDR_WIDTH-1:0] o_wr_pc,
  output logic [ADDR_WIDTH-1:0] o_wr_target,
  input  logic                  i_wr_ready,
  output logic [CNT_WIDTH-1:0]  o_cnt_branch,
  output logic [CNT_WIDTH-1:0]  o_cnt_mispred,
  output logic [CNT_WIDTH-1:0]  o_cnt_drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] pc_mem_q  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] tgt_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]      occ_q, occ_d;

  logic                  redir_valid_q, redir_valid_d;
  logic [ADDR_WIDTH-1:0] redir_pc_q, redir_pc_d;
  logic [CNT_WIDTH-1:0]  cnt_branch_q, cnt_branch_d;
  logic [CNT_WIDTH-1:0]  cnt_mispred_q, cnt_mispred_d;
  logic [CNT_WIDTH-1:0]  cnt_drop_q, cnt_drop_d;

  logic target_wrong, upd_req, mispred, full, empty, deq, enq, drop;

  // A taken branch needs a BTB write whenever the fetch-time prediction could not supply it.
  assign target_wrong = ~i_ex_pred_hit | (i_ex_pred_target != i_ex_target);
  assign upd_req      = i_ex_valid & i_ex_taken & target_wrong;
  assign mispred      = i_ex_valid & ((i_ex_taken & target_wrong) | (~i_ex_taken & i_ex_pred_hit));

  assign empty = (occ_q == '0);
  assign full  = (occ_q == OCC_W'(FIFO_DEPTH));
  assign deq   = ~empty & i_wr_ready;
  // A slot freed by this cycle's dequeue is reusable by this cycle's enqueue.
  assign enq   = upd_req & (~full | deq);
  assign drop  = upd_req & full & ~deq;

  always_comb begin
    redir_valid_d = mispred;
    redir_pc_d    = redir_pc_q;
    if (mispred) begin
      redir_pc_d = i_ex_taken ? i_ex_target : (i_ex_pc + ADDR_WIDTH'(4));
    end

    occ_d = occ_q;
    if (enq && !deq) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (deq && !enq) begin
      occ_d = occ_q - OCC_W'(1);
    end

    cnt_branch_d  = cnt_branch_q;
    cnt_mispred_d = cnt_mispred_q;
    cnt_drop_d    = cnt_drop_q;
    if (i_ex_valid && (cnt_branch_q != '1)) cnt_branch_d  = cnt_branch_q + CNT_WIDTH'(1);
    if (mispred && (cnt_mispred_q != '1))   cnt_mispred_d = cnt_mispred_q + CNT_WIDTH'(1);
    if (drop && (cnt_drop_q != '1))         cnt_drop_d    = cnt_drop_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        tgt_mem_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      cnt_branch_q  <= '0;
      cnt_mispred_q <= '0;
      cnt_drop_q    <= '0;
    end else begin
      if (enq) begin
        pc_mem_q[wr_ptr_q]  <= i_ex_pc;
        tgt_mem_q[wr_ptr_q] <= i_ex_target;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      occ_q         <= occ_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      cnt_branch_q  <= cnt_branch_d;
      cnt_mispred_q <= cnt_mispred_d;
      cnt_drop_q    <= cnt_drop_d;
    end
  end

  assign o_redirect_valid = redir_valid_q;
  assign o_redirect_pc    = redir_pc_q;
  assign o_wr_valid       = ~empty;
  assign o_wr_pc          = pc_mem_q[rd_ptr_q];
  assign o_wr_target      = tgt_mem_q[rd_ptr_q];
  assign o_cnt_branch     = cnt_branch_q;
  assign o_cnt_mispred    = cnt_mispred_q;
  assign o_cnt_drop       = cnt_drop_q;

endmodule
